network_bf_wb: RTL and testbench

Write-back stage directly downstream of the butterfly output crossbar. It captures the four routed coefficients `d0..d3` and aligns them with the bank address that was read for the same butterfly group. The address is delayed by the butterfly pipeline latency: 7 cycles for NTT, 13 for INTT. The stage then issues one in-place write to all four coefficient banks and signals when a full stage of groups has been written back.

---
 rtl/network_bf_wb.sv | 150 +++++++++++++++
 tb/tb_network_bf_wb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/network_bf_wb.sv
// Butterfly write-back stage: delays the read address by the butterfly latency and issues in-place 4-bank writes.
// Optional protocol checker enabled by defining NETWORK_BF_WB_CHK_EN.
module network_bf_wb #(
    parameter int data_width = 12,
    parameter int addr_width = 7,
    parameter int groups     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  start,
    input  logic                  rd_valid,
    input  logic [addr_width-1:0] rd_addr,
    input  logic [data_width-1:0] d0,
    input  logic [data_width-1:0] d1,
    input  logic [data_width-1:0] d2,
    input  logic [data_width-1:0] d3,
    output logic                  wen,
    output logic [addr_width-1:0] waddr,
    output logic [data_width-1:0] wdata0,
    output logic [data_width-1:0] wdata1,
    output logic [data_width-1:0] wdata2,
    output logic [data_width-1:0] wdata3,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  err
);

    localparam int cnt_w  = $clog2(groups) + 1;
    localparam int depth  = 13;

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_run  = 1'b1;

    logic [0:0]            state;
    logic                  mode_q;
    logic [cnt_w-1:0]      wr_cnt;
    logic [depth-1:0]      dl_vld_p;
    logic [addr_width-1:0] dl_addr_p [depth];

    logic                  run;
    logic                  start_acc;
    logic                  rd_acc;
    logic                  tap_vld;
    logic [addr_width-1:0] tap_addr;
    logic                  wr_last;

    assign run       = (state == st_run);
    assign start_acc = start & ~run;
    assign rd_acc    = rd_valid & run;

    // Stage 7 matches the NTT butterfly latency, stage 13 the INTT latency.
    assign tap_vld  = mode_q ? dl_vld_p[12]  : dl_vld_p[6];
    assign tap_addr = mode_q ? dl_addr_p[12] : dl_addr_p[6];
    assign wr_last  = tap_vld & run & (wr_cnt == cnt_w'(groups - 1));

    // Address delay line, one entry per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_vld_p <= '0;
            for (int i = 0; i < depth; i++) begin
                dl_addr_p[i] <= '0;
            end
        end else begin
            dl_vld_p     <= {dl_vld_p[depth-2:0], rd_acc};
            dl_addr_p[0] <= rd_addr;
            for (int i = 1; i < depth; i++) begin
                dl_addr_p[i] <= dl_addr_p[i-1];
            end
        end
    end

    // Stage control; writes landing while idle are not counted toward any stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= st_idle;
            mode_q <= 1'b0;
            wr_cnt <= '0;
        end else if (start_acc) begin
            state  <= st_run;
            mode_q <= sel;
            wr_cnt <= '0;
        end else if (run && tap_vld) begin
            if (wr_last) begin
                state  <= st_idle;
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Write issue stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen        <= 1'b0;
            stage_done <= 1'b0;
            busy       <= 1'b0;
            waddr      <= '0;
            wdata0     <= '0;
            wdata1     <= '0;
            wdata2     <= '0;
            wdata3     <= '0;
        end else begin
            wen        <= tap_vld;
            stage_done <= wr_last;
            if (start_acc) begin
                busy <= 1'b1;
            end else if (stage_done) begin
                busy <= 1'b0;
            end
            if (tap_vld) begin
                waddr  <= tap_addr;
                wdata0 <= d0;
                wdata1 <= d1;
                wdata2 <= d2;
                wdata3 <= d3;
            end
        end
    end

`ifdef NETWORK_BF_WB_CHK_EN
    logic [cnt_w-1:0] rd_cnt;
    logic             proto_err;

    assign proto_err = (rd_valid & ~run) | (start & run) |
                       (rd_acc & (rd_cnt >= cnt_w'(groups)));

    // Setting wins over the clear from a simultaneous accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_cnt <= '0;
                err    <= 1'b0;
            end else if (rd_acc && (rd_cnt < cnt_w'(groups))) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_network_bf_wb.sv
// Self-checking bench for network_bf_wb: random and directed stimulus against a cycle-indexed reference model.
module tb_network_bf_wb;

    localparam int DW = 12;
    localparam int AW = 7;
    localparam int G  = 128;
    localparam int N  = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sel = 1'b0;
    logic          start = 1'b0;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic          wen, busy, stage_done, err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata0, wdata1, wdata2, wdata3;

    network_bf_wb #(.data_width(DW), .addr_width(AW), .groups(G)) dut (
        .clk(clk), .rst(rst), .sel(sel), .start(start),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .wen(wen), .waddr(waddr),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
        .busy(busy), .stage_done(stage_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // History of the inputs seen at each rising edge
    bit            acc_h [N];
    logic [AW-1:0] addr_h [N];
    logic [DW-1:0] dh [N][4];
    int            last_rst = 0;

    // Reference model state
    bit            m_run, m_mode, m_busy, m_wen, m_done, m_err;
    int            m_wcnt, m_rdcnt;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wd [4];
    bit            chk_en;

    int wen_edge, rd_edge, wen_cnt, done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_run = 0; m_mode = 0; m_busy = 0; m_wen = 0; m_done = 0; m_err = 0;
        m_wcnt = 0; m_rdcnt = 0; m_waddr = '0;
        for (int k = 0; k < 4; k++) m_wd[k] = '0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_wen"}, wen, m_wen);
        check({pfx, "_stage_done"}, stage_done, m_done);
        check({pfx, "_busy"}, busy, m_busy);
        check({pfx, "_err"}, err, m_err);
        check({pfx, "_waddr"}, waddr, m_waddr);
        check({pfx, "_wdata0"}, wdata0, m_wd[0]);
        check({pfx, "_wdata1"}, wdata1, m_wd[1]);
        check({pfx, "_wdata2"}, wdata2, m_wd[2]);
        check({pfx, "_wdata3"}, wdata3, m_wd[3]);
    endtask

    // One rising edge: a read accepted at edge c is written at edge c+L
    // (L = 7 NTT / 13 INTT) with the data present at edge c+L.
    task automatic step();
        bit tap, acc, start_acc, done_prev, e;
        int L, src;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            last_rst   = cyc;
            acc_h[cyc] = 0;
            model_zero();
        end else begin
            acc         = rd_valid && m_run;
            acc_h[cyc]  = acc;
            addr_h[cyc] = rd_addr;
            dh[cyc]     = '{d0, d1, d2, d3};
            L   = m_mode ? 13 : 7;
            src = cyc - L;
            tap = (src > last_rst) && acc_h[src];
            done_prev = m_done;
            start_acc = start && !m_run;
            if (tap) begin
                m_waddr = addr_h[src];
                m_wd    = dh[cyc];
            end
            m_wen  = tap;
            m_done = tap && m_run && (m_wcnt == G - 1);
            if (tap && m_run) m_wcnt = m_done ? 0 : m_wcnt + 1;
            if (chk_en) begin
                e = (rd_valid && !m_run) || (start && m_run) || (acc && m_rdcnt >= G);
                if (start_acc) begin
                    m_err = 0;
                    m_rdcnt = 0;
                end else if (acc && m_rdcnt < G) begin
                    m_rdcnt++;
                end
                if (e) m_err = 1;
            end
            if (start_acc) begin
                m_run = 1; m_mode = sel; m_wcnt = 0; m_busy = 1;
            end else begin
                if (m_done) m_run = 0;
                if (done_prev) m_busy = 0;
            end
        end
        #1;
        check_outputs("cyc");
        if (wen === 1'b1) begin
            wen_cnt++;
            if (wen_edge < 0) wen_edge = cyc;
        end
        if (stage_done === 1'b1) done_cnt++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_zero();
        check_outputs("async_rst");
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
`ifdef NETWORK_BF_WB_CHK_EN
        chk_en = 1;
`else
        chk_en = 0;
`endif
        model_zero();
        wen_edge = -1; wen_cnt = 0; done_cnt = 0; rd_edge = 0;

        step();
        step();
        check("reset_wen", wen, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;

        // NTT single group: read sampled at edge N, wen seen after edge N+7 (cycle N+8)
        start = 1; sel = 0; step(); start = 0;
        rd_valid = 1; rd_addr = 7'h05; d0 = 1; d1 = 2; d2 = 3; d3 = 4;
        wen_edge = -1;
        step(); rd_edge = cyc; rd_valid = 0;
        repeat (16) step();
        check("ntt_lat", wen_edge - rd_edge, 7);
        check("ntt_waddr", waddr, 7'h05);
        check("ntt_wdata0", wdata0, 1);
        check("ntt_wdata3", wdata3, 4);
        async_reset();

        // INTT latency, sel toggled after start
        start = 1; sel = 1; step(); start = 0; sel = 0;
        rd_valid = 1; rd_addr = 7'h05;
        wen_edge = -1;
        step(); rd_edge = cyc; rd_valid = 0; sel = 1;
        repeat (3) step();
        sel = 0;
        repeat (16) step();
        check("intt_lat", wen_edge - rd_edge, 13);
        check("intt_waddr", waddr, 7'h05);
        async_reset();

        // Full stage, back-to-back
        start = 1; sel = 0; step(); start = 0;
        wen_cnt = 0; done_cnt = 0;
        for (int i = 0; i < G; i++) begin
            rd_valid = 1; rd_addr = AW'(i);
            d0 = DW'(i); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
            step();
        end
        rd_valid = 0;
        repeat (20) begin
            d0 = DW'($urandom); step();
        end
        check("full_wen_cnt", wen_cnt, G);
        check("full_done_cnt", done_cnt, 1);
        check("full_busy_end", busy, 1'b0);

        // Gapped stream, INTT
        start = 1; sel = 1; step(); start = 0;
        wen_cnt = 0; done_cnt = 0;
        for (int i = 0; i < G; i++) begin
            rd_valid = 1; rd_addr = AW'($urandom);
            d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
            step();
            rd_valid = 0;
            d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
            step();
        end
        repeat (20) step();
        check("gap_wen_cnt", wen_cnt, G);
        check("gap_done_cnt", done_cnt, 1);

        // Random traffic with stray starts, mode changes and overruns
        start = 1; sel = 1'($urandom); step(); start = 0;
        for (int i = 0; i < 400; i++) begin
            rd_valid = ($urandom_range(0, 3) != 0);
            rd_addr  = AW'($urandom);
            d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
            start = ($urandom_range(0, 40) == 0);
            sel   = 1'($urandom);
            step();
        end
        start = 0; rd_valid = 0;
        repeat (20) step();
        async_reset();

        // Protocol checker: read while idle, then cleared by start
        rd_valid = 1; rd_addr = AW'($urandom); step(); rd_valid = 0;
        step();
        check("chk_err_idle", err, chk_en);
        repeat (5) step();
        check("chk_err_held", err, chk_en);
        start = 1; sel = 0; step(); start = 0;
        check("chk_err_clear", err, 1'b0);
        start = 1; step(); start = 0;
        check("chk_err_start_run", err, chk_en);

        // Reset with five reads in flight
        async_reset();
        start = 1; sel = 0; step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1; rd_addr = AW'($urandom); step();
        end
        rd_valid = 0;
        step();
        async_reset();
        wen_cnt = 0;
        repeat (20) step();
        check("rst_no_wen", wen_cnt, 0);
        check("rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
